// File: rtl/alert_sequencer.sv
// Alert sequencer: arbitrates four alert requests and plays a ms-timed on/off beep cadence
// on tone_en, with fixed priority err > timeout > ok > key and preemption by higher priority.
module alert_sequencer #(
    parameter int T_TICK     = 12000,
    parameter int KEY_ON_MS  = 50,
    parameter int OK_ON_MS   = 100,
    parameter int OK_GAP_MS  = 100,
    parameter int OK_COUNT   = 2,
    parameter int TO_ON_MS   = 1000,
    parameter int ERR_ON_MS  = 500,
    parameter int ERR_GAP_MS = 500,
    parameter int ERR_COUNT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_key,
    input  logic       req_ok,
    input  logic       req_timeout,
    input  logic       req_err,
    input  logic       mute,
    output logic       tone_en,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    localparam int PRE_W = (T_TICK > 1) ? $clog2(T_TICK) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(T_TICK - 1);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] preCnt_q, preCnt_d;
    logic [15:0]      msCnt_q, msCnt_d;
    logic [2:0]       beepCnt_q, beepCnt_d;
    logic [1:0]       activeId_q, activeId_d;
    logic             tone_q, tone_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic       anyReq, tick, phaseEnd, lastBeep, preempt, clearCnt;
    logic [1:0] reqId;
    logic [15:0] phaseMs;

    // The alert id doubles as its priority, so preemption is a plain magnitude compare.
    function automatic logic [15:0] onMs(input logic [1:0] id);
        case (id)
            2'd0:    return 16'(KEY_ON_MS);
            2'd1:    return 16'(OK_ON_MS);
            2'd2:    return 16'(TO_ON_MS);
            default: return 16'(ERR_ON_MS);
        endcase
    endfunction

    function automatic logic [15:0] gapMs(input logic [1:0] id);
        case (id)
            2'd1:    return 16'(OK_GAP_MS);
            2'd3:    return 16'(ERR_GAP_MS);
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [2:0] beepCount(input logic [1:0] id);
        case (id)
            2'd1:    return 3'(OK_COUNT);
            2'd3:    return 3'(ERR_COUNT);
            default: return 3'd1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            preCnt_q   <= '0;
            msCnt_q    <= '0;
            beepCnt_q  <= '0;
            activeId_q <= '0;
            tone_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            preCnt_q   <= preCnt_d;
            msCnt_q    <= msCnt_d;
            beepCnt_q  <= beepCnt_d;
            activeId_q <= activeId_d;
            tone_q     <= tone_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Natural completion is tested before preemption so a request on the final cycle is dropped.
    always_comb begin
        state_d    = state_q;
        activeId_d = activeId_q;
        beepCnt_d  = beepCnt_q;
        done_d     = 1'b0;
        clearCnt   = 1'b0;

        anyReq = req_err | req_timeout | req_ok | req_key;
        if (req_err)          reqId = 2'd3;
        else if (req_timeout) reqId = 2'd2;
        else if (req_ok)      reqId = 2'd1;
        else                  reqId = 2'd0;

        tick     = (preCnt_q == PRE_MAX);
        phaseMs  = (state_q == GAP) ? gapMs(activeId_q) : onMs(activeId_q);
        phaseEnd = (state_q != IDLE) && tick && (msCnt_q == phaseMs - 16'd1);
        lastBeep = (beepCnt_q == beepCount(activeId_q) - 3'd1);
        preempt  = (state_q != IDLE) && anyReq && (reqId > activeId_q);

        if (state_q == IDLE) begin
            preCnt_d = '0;
            msCnt_d  = '0;
        end else if (tick) begin
            preCnt_d = '0;
            msCnt_d  = msCnt_q + 16'd1;
        end else begin
            preCnt_d = preCnt_q + PRE_W'(1);
            msCnt_d  = msCnt_q;
        end

        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d    = ON;
                    activeId_d = reqId;
                    beepCnt_d  = '0;
                end
            end
            ON: begin
                if (phaseEnd && lastBeep) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    beepCnt_d = '0;
                    clearCnt  = 1'b1;
                end else if (preempt) begin
                    activeId_d = reqId;
                    beepCnt_d  = '0;
                    clearCnt   = 1'b1;
                end else if (phaseEnd) begin
                    state_d  = GAP;
                    clearCnt = 1'b1;
                end
            end
            GAP: begin
                if (preempt) begin
                    state_d    = ON;
                    activeId_d = reqId;
                    beepCnt_d  = '0;
                    clearCnt   = 1'b1;
                end else if (phaseEnd) begin
                    state_d   = ON;
                    beepCnt_d = beepCnt_q + 3'd1;
                    clearCnt  = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                clearCnt = 1'b1;
            end
        endcase

        if (clearCnt) begin
            preCnt_d = '0;
            msCnt_d  = '0;
        end

        busy_d = (state_d != IDLE);
        tone_d = (state_d == ON) && !mute;
    end

    assign tone_en   = tone_q;
    assign busy      = busy_q;
    assign active_id = activeId_q;
    assign done      = done_q;

endmodule

// File: doc/alert_sequencer.md
Name: alert_sequencer

Overview:
- Arbitrates four single-cycle alert requests from the digital-locker control path: key click, unlock OK, entry timeout, password error.
- Plays one on/off beep cadence per alert and drives tone_en to the 1 kHz tone generator that feeds the buzzer pin.
- Timing comes from a parameterised ms tick, so cadences are set in milliseconds, independent of clk.

Parameters:
- T_TICK, 12000: clk cycles per 1 ms tick (12 MHz clk).
- KEY_ON_MS, 50: key-click beep length; 1 beep.
- OK_ON_MS, 100: OK beep length.
- OK_GAP_MS, 100: OK silence between beeps.
- OK_COUNT, 2: OK beep count.
- TO_ON_MS, 1000: timeout beep length; 1 beep.
- ERR_ON_MS, 500: error beep length.
- ERR_GAP_MS, 500: error silence between beeps.
- ERR_COUNT, 3: error beep count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- req_key  in  1  key-click request pulse.
- req_ok  in  1  unlock-OK request pulse.
- req_timeout  in  1  timeout request pulse.
- req_err  in  1  password-error request pulse.
- mute  in  1  level; forces tone_en low, sequencing continues.
- tone_en  out  1  registered; high = tone generator runs.
- busy  out  1  registered; high while a cadence is active.
- active_id  out  2  registered; 0 key, 1 ok, 2 timeout, 3 err.
- done  out  1  registered one-cycle pulse on natural cadence completion.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock clk. All outputs 0; FSM IDLE; all counters 0.
- Fixed priority: err > timeout > ok > key. Requests are sampled every cycle.
- FSM states: IDLE, ON, GAP.
- IDLE: on any request, latch the highest-priority id, load its cadence and enter ON. Other simultaneous requests are dropped.
- Latency: request at cycle n gives busy=1, tone_en=1 (if !mute) and active_id valid at n+1.
- ON lasts exactly ON_MS*T_TICK cycles. On expiry:
  - beeps played < COUNT: go to GAP.
  - otherwise: go to IDLE; same edge sets busy=0, tone_en=0, done=1 for one cycle.
- GAP lasts exactly GAP_MS*T_TICK cycles with tone_en=0, then ON with beep count +1.
- Counters:
  - tick prescaler: 0..T_TICK-1, wraps, producing a 1-cycle tick.
  - ms counter: 16 bits, compared with the phase length minus 1 on tick.
  - beep counter: 3 bits.
  - Prescaler and ms counter clear on every phase entry.
  - Widths must hold the default values without overflow.
- Preemption, while busy:
  - Strictly higher-priority request: restart in ON with the new cadence at the next cycle, all counters cleared. No done pulse. tone_en stays or goes high with no low glitch cycle.
  - Equal- or lower-priority request: ignored.
- A request arriving in the same cycle as natural completion is ignored. done still pulses; IDLE is entered.
- mute: tone_en = phase_on & !mute, registered. busy, done and timing are unaffected.
- Reset mid-cadence: immediate return to reset state. No done pulse.

Test Plan:
- T_TICK=10. req_key at cycle 0 -> tone_en high cycles 1..500; busy low and done=1 at cycle 501; active_id=0.
- req_ok -> tone_en high 1000 cycles, low 1000, high 1000; done after 3000 cycles; active_id=1.
- req_err -> 3 ON bursts of 5000 cycles with 2 gaps of 5000 cycles; total 25000 cycles, then done.
- req_key and req_timeout in the same cycle -> active_id=2; single 10000-cycle beep; key dropped.
- req_ok running, req_err at cycle 1500 -> active_id=3 at 1501; new 5000-cycle ON from 1501; no done at switch. Then req_key mid-err -> ignored.
- mute high throughout req_err -> tone_en always 0; busy 25000 cycles; done pulses. rst_n low mid-ON -> outputs 0 asynchronously; no done.
